// File: rtl/oam_dma_ctrl.sv
// NES sprite DMA engine: passes CPU bus cycles through to memory when idle and,
// on a write to the DMA register, halts the CPU and copies one 256-byte page into OAM.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_wen,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_wen,
    input  logic [7:0]  mem_rdata,
    output logic        dma_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  buf_q, buf_d;
    logic        parity_q, parity_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            buf_q    <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            buf_q    <= buf_d;
            parity_q <= parity_d;
        end
    end

    assign cpu_rdata = mem_rdata;

    // Outside IDLE the engine owns the bus; the default is a dummy read of the page base.
    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        parity_d  = ~parity_q;
        mem_addr  = {page_q, 8'h00};
        mem_wdata = 8'h00;
        mem_wen   = 1'b0;
        cpu_rdy   = 1'b0;
        dma_busy  = 1'b1;

        case (state_q)
            S_IDLE: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_wen   = cpu_wen;
                cpu_rdy   = 1'b1;
                dma_busy  = 1'b0;
                if (cpu_wen && (cpu_addr == DMA_REG_ADDR)) begin
                    page_d  = cpu_wdata;
                    idx_d   = 8'h00;
                    state_d = S_HALT;
                end
            end
            // Reads must start on an even cycle, so an extra dummy cycle is
            // inserted when the cycle after HALT would be odd.
            S_HALT: begin
                state_d = parity_q ? S_READ : S_ALIGN;
            end
            S_ALIGN: begin
                state_d = S_READ;
            end
            S_READ: begin
                mem_addr = {page_q, idx_q};
                buf_d    = mem_rdata;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                mem_addr  = OAM_DATA_ADDR;
                mem_wdata = buf_q;
                mem_wen   = 1'b1;
                if (idx_q == 8'hFF) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
